// File: rtl/note_playback_sequencer.sv
// Per-voice note event playback: a current slot plus a one-deep queue per voice,
// regenerating the note value/octave/on-mask stream with one strobe per tick.
module note_playback_sequencer #(
    parameter int VOICES = 5,
    parameter int DUR_W  = 30
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   tick_in,
    input  logic                   event_valid_in,
    output logic                   event_ready_out,
    input  logic [2:0]             event_voice_in,
    input  logic [7:0]             event_note_in,
    input  logic [DUR_W-1:0]       event_duration_in,
    output logic [VOICES-1:0][3:0] note_value_array_out,
    output logic [VOICES-1:0][3:0] octave_count_out,
    output logic [VOICES-1:0]      note_on_out,
    output logic                   valid_note_out,
    output logic [VOICES-1:0]      voice_busy_out,
    output logic                   bad_voice_out
);

    logic [VOICES-1:0][7:0]       cur_note_q, cur_note_d;
    logic [VOICES-1:0][DUR_W-1:0] rem_q, rem_d;
    logic [VOICES-1:0]            play_q, play_d;
    logic [VOICES-1:0][7:0]       nxt_note_q, nxt_note_d;
    logic [VOICES-1:0][DUR_W-1:0] nxt_dur_q, nxt_dur_d;
    logic [VOICES-1:0]            nxt_v_q, nxt_v_d;
    logic [VOICES-1:0][3:0]       val_q, val_d;
    logic [VOICES-1:0][3:0]       oct_q, oct_d;
    logic [VOICES-1:0]            on_q, on_d;
    logic                         valid_q;
    logic                         bad_q;
    logic                         in_range;
    logic                         sel_busy;
    logic                         accept;

    assign in_range = (32'(event_voice_in) < VOICES);

    always_comb begin
        sel_busy = 1'b0;
        for (int i = 0; i < VOICES; i++) begin
            if (32'(event_voice_in) == i) begin
                sel_busy = nxt_v_q[i];
            end
        end
    end

    // Out-of-range events are always taken so they can be flagged and dropped.
    assign event_ready_out = rst_n_in && (!in_range || !sel_busy);
    assign accept = event_valid_in && event_ready_out;

    always_comb begin
        cur_note_d = cur_note_q;
        rem_d      = rem_q;
        play_d     = play_q;
        nxt_note_d = nxt_note_q;
        nxt_dur_d  = nxt_dur_q;
        nxt_v_d    = nxt_v_q;
        on_d       = '0;
        val_d      = '1;
        oct_d      = '1;
        for (int i = 0; i < VOICES; i++) begin
            if (tick_in) begin
                if (play_q[i]) begin
                    if (rem_q[i] != '0) begin
                        rem_d[i] = rem_q[i] - DUR_W'(1);
                    end else if (nxt_v_q[i]) begin
                        cur_note_d[i] = nxt_note_q[i];
                        rem_d[i]      = nxt_dur_q[i];
                        nxt_v_d[i]    = 1'b0;
                    end else begin
                        play_d[i] = 1'b0;
                    end
                end else if (nxt_v_q[i]) begin
                    cur_note_d[i] = nxt_note_q[i];
                    rem_d[i]      = nxt_dur_q[i];
                    play_d[i]     = 1'b1;
                    nxt_v_d[i]    = 1'b0;
                end
            end
            // Accept only fires on an empty queue, so it never races the tick.
            if (accept && in_range && (32'(event_voice_in) == i)) begin
                nxt_note_d[i] = event_note_in;
                nxt_dur_d[i]  = event_duration_in;
                nxt_v_d[i]    = 1'b1;
            end
            on_d[i] = play_d[i] && (cur_note_d[i] != 8'hFF);
            if (on_d[i]) begin
                val_d[i] = cur_note_d[i][7:4];
                oct_d[i] = cur_note_d[i][3:0];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            cur_note_q <= '0;
            rem_q      <= '0;
            play_q     <= '0;
            nxt_note_q <= '0;
            nxt_dur_q  <= '0;
            nxt_v_q    <= '0;
            on_q       <= '0;
            val_q      <= '1;
            oct_q      <= '1;
            valid_q    <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            cur_note_q <= cur_note_d;
            rem_q      <= rem_d;
            play_q     <= play_d;
            nxt_note_q <= nxt_note_d;
            nxt_dur_q  <= nxt_dur_d;
            nxt_v_q    <= nxt_v_d;
            valid_q    <= tick_in;
            bad_q      <= accept && !in_range;
            if (tick_in) begin
                on_q  <= on_d;
                val_q <= val_d;
                oct_q <= oct_d;
            end
        end
    end

    assign note_value_array_out = val_q;
    assign octave_count_out     = oct_q;
    assign note_on_out          = on_q;
    assign valid_note_out       = valid_q;
    assign voice_busy_out       = play_q | nxt_v_q;
    assign bad_voice_out        = bad_q;

endmodule

// File: tb/tb_note_playback_sequencer.sv
// Directed bench for note_playback_sequencer: a vector table for plain playback
// plus hand sequences for queueing, rests, tick collisions, bad voices and reset.
module tb_note_playback_sequencer;
    localparam int V  = 5;
    localparam int DW = 30;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic          ev_v = 1'b0;
    logic [2:0]    ev_voice = '0;
    logic [7:0]    ev_note = '0;
    logic [DW-1:0] ev_dur = '0;

    logic [V-1:0][3:0] nv;
    logic [V-1:0][3:0] oc;
    logic [V-1:0]      on;
    logic [V-1:0]      busy;
    logic              vn;
    logic              rdy;
    logic              bad;

    int checks = 0;
    int errors = 0;

    note_playback_sequencer #(.VOICES(V), .DUR_W(DW)) dut (
        .clk_in               (clk),
        .rst_n_in             (rst_n),
        .tick_in              (tick),
        .event_valid_in       (ev_v),
        .event_ready_out      (rdy),
        .event_voice_in       (ev_voice),
        .event_note_in        (ev_note),
        .event_duration_in    (ev_dur),
        .note_value_array_out (nv),
        .octave_count_out     (oc),
        .note_on_out          (on),
        .valid_note_out       (vn),
        .voice_busy_out       (busy),
        .bad_voice_out        (bad)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          tk;
        logic          ev;
        logic [2:0]    vc;
        logic [7:0]    nt;
        logic [DW-1:0] du;
        logic          xv;
        logic [4:0]    xon;
        logic [4:0]    xbusy;
        logic [19:0]   xval;
        logic [19:0]   xoct;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic tk, input logic ev,
                                input logic [2:0] vc, input logic [7:0] nt,
                                input logic [DW-1:0] du, input logic xv,
                                input logic [4:0] xon, input logic [4:0] xbusy,
                                input logic [19:0] xval, input logic [19:0] xoct);
        vec_t r;
        r.tk = tk; r.ev = ev; r.vc = vc; r.nt = nt; r.du = du;
        r.xv = xv; r.xon = xon; r.xbusy = xbusy; r.xval = xval; r.xoct = xoct;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic t, input logic v, input logic [2:0] vc,
                       input logic [7:0] n, input logic [DW-1:0] d);
        tick = t; ev_v = v; ev_voice = vc; ev_note = n; ev_dur = d;
        @(posedge clk);
        #1;
        tick = 1'b0;
        ev_v = 1'b0;
    endtask

    task automatic outs(input string tag, input logic xv, input logic [4:0] xon,
                        input logic [4:0] xbusy, input logic [19:0] xval,
                        input logic [19:0] xoct);
        chk({tag, " valid"}, 32'(vn), 32'(xv));
        chk({tag, " on"}, 32'(on), 32'(xon));
        chk({tag, " busy"}, 32'(busy), 32'(xbusy));
        chk({tag, " val"}, 32'(nv), 32'(xval));
        chk({tag, " oct"}, 32'(oc), 32'(xoct));
    endtask

    initial begin
        // single note v0 8'h34 dur 3, one idle cycle mid-play
        tbl.push_back(mk(0, 1, 0, 8'h34, 3, 0, 5'h00, 5'h01, 20'hFFFFF, 20'hFFFFF));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 5'h01, 5'h01, 20'hFFFF3, 20'hFFFF4));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 5'h01, 5'h01, 20'hFFFF3, 20'hFFFF4));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 5'h01, 5'h01, 20'hFFFF3, 20'hFFFF4));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 5'h01, 5'h01, 20'hFFFF3, 20'hFFFF4));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 5'h01, 5'h01, 20'hFFFF3, 20'hFFFF4));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 5'h00, 5'h00, 20'hFFFFF, 20'hFFFFF));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 5'h00, 5'h00, 20'hFFFFF, 20'hFFFFF));
        // parallel voices, voice i duration i
        tbl.push_back(mk(0, 1, 0, 8'h10, 0, 0, 5'h00, 5'h01, 20'hFFFFF, 20'hFFFFF));
        tbl.push_back(mk(0, 1, 1, 8'h21, 1, 0, 5'h00, 5'h03, 20'hFFFFF, 20'hFFFFF));
        tbl.push_back(mk(0, 1, 2, 8'h32, 2, 0, 5'h00, 5'h07, 20'hFFFFF, 20'hFFFFF));
        tbl.push_back(mk(0, 1, 3, 8'h43, 3, 0, 5'h00, 5'h0F, 20'hFFFFF, 20'hFFFFF));
        tbl.push_back(mk(0, 1, 4, 8'h54, 4, 0, 5'h00, 5'h1F, 20'hFFFFF, 20'hFFFFF));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 5'h1F, 5'h1F, 20'h54321, 20'h43210));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 5'h1E, 5'h1E, 20'h5432F, 20'h4321F));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 5'h1C, 5'h1C, 20'h543FF, 20'h432FF));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 5'h18, 5'h18, 20'h54FFF, 20'h43FFF));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 5'h10, 5'h10, 20'h5FFFF, 20'h4FFFF));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 5'h00, 5'h00, 20'hFFFFF, 20'hFFFFF));

        // reset with events offered
        rst_n = 1'b0;
        ev_v = 1'b1; ev_voice = 3'd0; ev_note = 8'h34; ev_dur = 3;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("rst ready", 32'(rdy), 32'd0);
            outs("rst", 1'b0, 5'h00, 5'h00, 20'hFFFFF, 20'hFFFFF);
            chk("rst bad", 32'(bad), 32'd0);
        end
        rst_n = 1'b1;
        ev_v = 1'b0;
        #1;
        chk("rel ready", 32'(rdy), 32'd1);
        @(posedge clk);
        #1;
        chk("rel busy", 32'(busy), 32'd0);

        for (int k = 0; k < tbl.size(); k++) begin
            cyc(tbl[k].tk, tbl[k].ev, tbl[k].vc, tbl[k].nt, tbl[k].du);
            outs($sformatf("vec%0d", k), tbl[k].xv, tbl[k].xon, tbl[k].xbusy,
                 tbl[k].xval, tbl[k].xoct);
        end

        // gapless queue on voice 2
        cyc(0, 1, 2, 8'h12, 1);
        cyc(1, 0, 2, 8'h00, 0);
        outs("gq t1", 1'b1, 5'h04, 5'h04, 20'hFF1FF, 20'hFF2FF);
        ev_voice = 3'd2; #1;
        chk("gq ready empty", 32'(rdy), 32'd1);
        cyc(0, 1, 2, 8'h55, 0);
        ev_v = 1'b1; ev_voice = 3'd2; ev_note = 8'h77; ev_dur = 5; tick = 1'b1;
        #1;
        chk("gq ready full", 32'(rdy), 32'd0);
        @(posedge clk);
        #1;
        tick = 1'b0;
        chk("gq ready held", 32'(rdy), 32'd0);
        ev_v = 1'b0;
        outs("gq t2", 1'b1, 5'h04, 5'h04, 20'hFF1FF, 20'hFF2FF);
        cyc(1, 0, 2, 8'h00, 0);
        outs("gq t3", 1'b1, 5'h04, 5'h04, 20'hFF5FF, 20'hFF5FF);
        ev_voice = 3'd2; #1;
        chk("gq ready after", 32'(rdy), 32'd1);
        cyc(1, 0, 2, 8'h00, 0);
        outs("gq t4", 1'b1, 5'h00, 5'h00, 20'hFFFFF, 20'hFFFFF);
        cyc(1, 0, 2, 8'h00, 0);
        outs("gq t5", 1'b1, 5'h00, 5'h00, 20'hFFFFF, 20'hFFFFF);

        // rest on voice 1 accepted together with a tick
        ev_voice = 3'd1; #1;
        chk("rest ready", 32'(rdy), 32'd1);
        cyc(1, 1, 1, 8'hFF, 2);
        outs("rest t0", 1'b1, 5'h00, 5'h02, 20'hFFFFF, 20'hFFFFF);
        for (int k = 1; k <= 3; k++) begin
            cyc(1, 0, 0, 8'h00, 0);
            outs($sformatf("rest t%0d", k), 1'b1, 5'h00, 5'h02, 20'hFFFFF, 20'hFFFFF);
        end
        cyc(1, 0, 0, 8'h00, 0);
        outs("rest t4", 1'b1, 5'h00, 5'h00, 20'hFFFFF, 20'hFFFFF);
        cyc(0, 0, 0, 8'h00, 0);
        chk("valid drop", 32'(vn), 32'd0);

        // out-of-range voice
        ev_voice = 3'd6; #1;
        chk("bad ready", 32'(rdy), 32'd1);
        cyc(0, 1, 6, 8'h23, 2);
        chk("bad pulse", 32'(bad), 32'd1);
        chk("bad busy", 32'(busy), 32'd0);
        cyc(1, 0, 0, 8'h00, 0);
        chk("bad clear", 32'(bad), 32'd0);
        outs("bad tick", 1'b1, 5'h00, 5'h00, 20'hFFFFF, 20'hFFFFF);

        // reset during a long note on voice 3
        cyc(0, 1, 3, 8'h66, 10);
        cyc(1, 0, 0, 8'h00, 0);
        outs("mr t1", 1'b1, 5'h08, 5'h08, 20'hF6FFF, 20'hF6FFF);
        cyc(1, 0, 0, 8'h00, 0);
        cyc(1, 0, 0, 8'h00, 0);
        outs("mr t3", 1'b1, 5'h08, 5'h08, 20'hF6FFF, 20'hF6FFF);
        rst_n = 1'b0;
        cyc(1, 1, 0, 8'h11, 0);
        outs("mr rst", 1'b0, 5'h00, 5'h00, 20'hFFFFF, 20'hFFFFF);
        chk("mr ready", 32'(rdy), 32'd0);
        rst_n = 1'b1;
        cyc(1, 0, 0, 8'h00, 0);
        outs("mr post", 1'b1, 5'h00, 5'h00, 20'hFFFFF, 20'hFFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/note_playback_sequencer.md
# note_playback_sequencer

Plays back recorded note events: accepts `{note, duration}` events per voice and regenerates the multi-voice note stream consumed by the synthesis path. The stream has the same form the duration tracker ingests: note value array, octave array, note-on mask and a valid strobe. Sits between the recording memory read port and the tone generators. A recorded duration D means the note was sampled D+1 times, so playback holds each event for exactly D+1 ticks.

## Interface
Parameters:
- `VOICES`, 5: number of independent voices.
- `DUR_W`, 30: duration width in ticks.

Ports:
- `clk_in` in 1: system clock.
- `rst_n_in` in 1: reset, synchronous, active-low.
- `tick_in` in 1: sample strobe, one cycle wide; all playback timing counts these.
- `event_valid_in` in 1: event offered.
- `event_ready_out` out 1: event accepted when high with valid.
- `event_voice_in` in 3: target voice index.
- `event_note_in` in 8: `{note[7:4], octave[3:0]}`; 8'hFF = rest.
- `event_duration_in` in DUR_W: hold length minus one, in ticks.
- `note_value_array_out` out VOICES x 4: current note per voice; 4'hF when off.
- `octave_count_out` out VOICES x 4: current octave per voice; 4'hF when off.
- `note_on_out` out VOICES: per-voice note-on mask.
- `valid_note_out` out 1: one-cycle strobe, outputs updated.
- `voice_busy_out` out VOICES: voice has a current or queued event.
- `bad_voice_out` out 1: one-cycle pulse, event dropped for out-of-range voice.

## Operation
- Each voice has a current slot `{note, remaining, playing}` and a one-deep next slot `{note, duration, next_valid}`.
- `event_ready_out` = !next_valid[event_voice_in] when the voice index is < VOICES. It is 1 for an out-of-range index. It is forced to 0 while `rst_n_in` is low. It is combinational on `event_voice_in`.
- Accept (valid && ready):
  - In-range index: load the next slot and set next_valid.
  - Out-of-range index: discard the event and pulse `bad_voice_out` the next cycle.
- On `tick_in`, each voice is evaluated independently, using state from before this cycle's accept:
  - playing and remaining > 0: decrement remaining.
  - playing, remaining == 0, next_valid: move next into current, set remaining = duration, clear next_valid. This is a gapless handoff.
  - playing, remaining == 0, no next: playing = 0. The voice goes off.
  - not playing and next_valid: move next into current and set playing = 1.
  - otherwise: no change.
- Output regs update only on the cycle after `tick_in`, from the post-tick state:
  - note_on = playing && note != 8'hFF.
  - note/octave fields = current note when note_on, else 4'hF/4'hF.
- A rest event (8'hFF) occupies its duration with note_on = 0.
- `voice_busy_out[i]` = playing[i] || next_valid[i].
- An event accepted in the same cycle as `tick_in` is not seen by that tick. It starts or hands off on the following tick.
- `remaining` is DUR_W bits and never wraps: decrement only occurs when remaining > 0. Duration all-ones holds for 2^DUR_W ticks.

## Timing
- Reset (synchronous, `rst_n_in` low at a clock edge) sets:
  - all slots empty, playing = 0, remaining = 0;
  - note_on_out = 0, note/octave outputs = 4'hF;
  - valid_note_out = 0, bad_voice_out = 0, voice_busy_out = 0.
- Reset mid-playback aborts every voice on that edge. Events offered during reset are not accepted.
- Latency: `tick_in` at cycle t gives updated outputs and `valid_note_out` = 1 at cycle t+1.
  - `valid_note_out` is high for exactly one cycle per tick, even if nothing changed.
- Idle voice: an event accepted at cycle a, with first tick at t > a, gives note_on at t+1.
- Back-to-back events on one voice produce no off-tick between them.
- `tick_in` on consecutive cycles is legal and is processed every cycle.

## Test plan
- Reset: hold `rst_n_in` low 3 cycles with valid events offered. Expect no acceptance, all outputs at reset values, `event_ready_out` = 0. On release, ready = 1.
- Single note: voice 0, note 8'h34, duration 3, then 6 ticks. Expect note_on_out[0] = 1 with value 3 and octave 4 for exactly ticks 1-4. Ticks 5-6 give note_on = 0 and fields 4'hF. `valid_note_out` follows each tick by 1 cycle.
- Gapless queue: voice 2 gets 8'h12 dur 1, then 8'h55 dur 0 offered immediately. Expect ready = 0 on a third offer until the first handoff. Expect note_on high for 3 consecutive ticks (1,2 → 5,5), then off.
- Rest, and accept colliding with tick: voice 1 gets 8'hFF dur 2, accepted in the same cycle as a tick. That tick shows voice 1 off. The next 3 ticks show note_on = 0 while voice_busy = 1. Busy clears after the 3rd.
- Parallel voices: all 5 voices loaded with different notes and durations 0-4. Check each voice ends independently on the correct tick.
- Bad voice, and reset mid-play: voice 6 offered → accepted, `bad_voice_out` pulses, no state change. Then assert reset during a dur-10 note → all outputs return to reset values on the next edge.
